// File: rtl/common.sv
// Shared types for the PS/2 receive path.
package common;

  // Reason the most recent frame was discarded.
  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrFraming = 2'd1,
    ErrParity  = 2'd2,
    ErrTimeout = 2'd3
  } ps2_err_t;

endpackage

// File: rtl/ps2_filter.sv
// Synchronises and deglitches one PS/2 line, and flags filtered falling edges.
module ps2_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic async_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            fclk_q, fclk_d;
  logic            fclk_dly_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Run counter: the filtered level follows the synced line only after a full
  // run of FILTER_CYCLES consecutive differing samples.
  always_comb begin
    fclk_d = fclk_q;
    cnt_d  = '0;
    if (sync2_q != fclk_q) begin
      if (cnt_q == CntLast) begin
        fclk_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Synchroniser, filtered level and its one-cycle delayed copy; idle bus is high.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      fclk_q     <= 1'b1;
      fclk_dly_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= async_i;
      sync2_q    <= sync1_q;
      fclk_q     <= fclk_d;
      fclk_dly_q <= fclk_q;
      cnt_q      <= cnt_d;
    end
  end

  assign filt_o = fclk_q;
  assign fall_o = fclk_dly_q & ~fclk_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: frames bits on filtered clock falls, checks
// start/parity/stop, aborts stalled frames and emits one-cycle result strobes.
module ps2_receiver import common::*; #(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       ps2_clk_async_i,
  input  logic       ps2_data_async_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       error_o,
  output ps2_err_t   error_kind_o,
  output logic       busy_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRecv = 1'b1;

  logic clk_filt, clk_fall, fall;
  logic data_s1_q, data_s2_q;

  logic [0:0]      state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  ps2_err_t        kind_q, kind_d;

  ps2_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .async_i (ps2_clk_async_i),
    .filt_o  (clk_filt),
    .fall_o  (clk_fall)
  );

  // A fall always leaves the filtered line low; qualifying on it keeps the two consistent.
  assign fall = clk_fall & ~clk_filt;

  // Bare 2-flop synchroniser for the data line.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      data_s1_q <= ps2_data_async_i;
      data_s2_q <= data_s1_q;
    end
  end

  // Frame FSM: bit counting, shifting, stop-bit evaluation and stall timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    kind_d    = kind_q;
    case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (fall) begin
          if (!data_s2_q) begin
            state_d   = StRecv;
            bit_cnt_d = 4'd1;
          end else begin
            error_d = 1'b1;
            kind_d  = ErrFraming;
          end
        end
      end
      StRecv: begin
        if (fall) begin
          tmo_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shift_d = {data_s2_q, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            parity_d = data_s2_q;
          end else begin
            state_d = StIdle;
            if (!data_s2_q) begin
              error_d = 1'b1;
              kind_d  = ErrFraming;
            end else if (!(^{shift_q, parity_q})) begin
              error_d = 1'b1;
              kind_d  = ErrParity;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end else if (tmo_q == TmoLast) begin
          // Window is counted from the last fall; expiry abandons the frame.
          state_d = StIdle;
          tmo_d   = '0;
          error_d = 1'b1;
          kind_d  = ErrTimeout;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      kind_q    <= ErrNone;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      kind_q    <= kind_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign error_o      = error_q;
  assign error_kind_o = kind_q;
  assign busy_o       = (state_q == StRecv);

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: drives PS/2 frames on the raw pins and
// checks the strobes against a frame-level outcome model.
module tb_ps2_receiver;

  localparam int unsigned Filt = 8;
  localparam int unsigned Tmo  = 5000;
  localparam int unsigned Half = 50;  // 2 us bit period at 50 MHz

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, error_o, busy_o;
  logic [1:0] error_kind_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int overlap = 0;
  int last_fall_cyc = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    logic [1:0] k;
    int         cyc;
  } ev_t;
  ev_t evq[$];
  ev_t mon_e;

  ps2_receiver #(
    .FILTER_CYCLES (Filt),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .ps2_clk_async_i (ps2_clk),
    .ps2_data_async_i(ps2_dat),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .error_o         (error_o),
    .error_kind_o    (error_kind_o),
    .busy_o          (busy_o)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the cycle number it was seen in.
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid_o && error_o) overlap++;
      if (valid_o) begin
        mon_e.is_err = 1'b0; mon_e.d = data_o; mon_e.k = 2'd0; mon_e.cyc = cyc;
        evq.push_back(mon_e);
      end
      if (error_o) begin
        mon_e.is_err = 1'b1; mon_e.d = 8'h00; mon_e.k = error_kind_o; mon_e.cyc = cyc;
        evq.push_back(mon_e);
      end
    end
  end

  // Frame outcome from the protocol rules: 0 = good byte, else error code.
  function automatic int frame_outcome(input logic [7:0] d, input bit par_flip, input bit stop_b);
    int par, ones;
    par  = ($countones(d) % 2 == 0) ? 1 : 0;
    if (par_flip) par = 1 - par;
    ones = $countones(d) + par;
    if (!stop_b) return 1;
    if (ones % 2 == 0) return 2;
    return 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One device bit: data set at the start of the high phase, optional short glitch.
  task automatic send_bit(input bit b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(15); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(Half - 18);
    end else begin
      wait_cyc(Half);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(Half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_b,
                            input int nfalls, input bit glitch);
    bit bits [11];
    bit par;
    par = ($countones(d) % 2 == 0);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = par ^ par_flip;
    bits[10] = stop_b;
    for (int i = 0; i < nfalls; i++) send_bit(bits[i], glitch && (i >= 3) && (i <= 7));
    ps2_dat = 1'b1;
    wait_cyc(40);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    n_cmp++;
    if ({data_o, valid_o, error_o} !== 10'h000) begin
      n_fail++; $display("FAIL reset_data_strobes: got %h want 000", {data_o, valid_o, error_o});
    end
    n_cmp++;
    if ({error_kind_o, busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_kind_busy: got %b want 000", {error_kind_o, busy_o});
    end
    reset_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_single_byte();
    evq.delete();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    n_cmp++;
    if (evq.size() != 1 || evq[0].is_err || evq[0].d !== 8'h1C) begin
      n_fail++; $display("FAIL single_1c: got %0d events first d=%h want 1 valid d=1c",
                         evq.size(), (evq.size() > 0) ? evq[0].d : 8'hxx);
    end
    n_cmp++;
    if (evq.size() < 1 || evq[0].cyc != last_fall_cyc + 3 + Filt) begin
      n_fail++; $display("FAIL single_latency: got cyc %0d want %0d",
                         (evq.size() > 0) ? evq[0].cyc : -1, last_fall_cyc + 3 + Filt);
    end
    wait_cyc(200);
    n_cmp++;
    if (data_o !== 8'h1C) begin
      n_fail++; $display("FAIL single_hold: got %h want 1c", data_o);
    end
  endtask

  task automatic test_back_to_back();
    evq.delete();
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    wait_cyc(200);
    send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0);
    n_cmp++;
    if (evq.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d events want 2", evq.size());
    end else begin
      n_cmp++;
      if (evq[0].is_err || evq[0].d !== 8'hF0 || evq[1].is_err || evq[1].d !== 8'h33) begin
        n_fail++; $display("FAIL b2b_bytes: got %h/%0d %h/%0d want f0/0 33/0",
                           evq[0].d, evq[0].is_err, evq[1].d, evq[1].is_err);
      end
    end
  endtask

  task automatic test_parity_error();
    evq.delete();
    send_frame(8'h33, 1'b1, 1'b1, 11, 1'b0);
    n_cmp++;
    if (evq.size() != 1 || !evq[0].is_err || evq[0].k !== 2'd2) begin
      n_fail++; $display("FAIL parity_err: got %0d events kind %0d want 1 error kind 2",
                         evq.size(), (evq.size() > 0) ? evq[0].k : 2'bxx);
    end
    n_cmp++;
    if (data_o !== 8'h33 || error_kind_o !== 2'd2) begin
      n_fail++; $display("FAIL parity_hold: got data %h kind %0d want 33 2", data_o, error_kind_o);
    end
  endtask

  task automatic test_framing();
    evq.delete();
    send_frame(8'hA5, 1'b0, 1'b0, 11, 1'b0);
    n_cmp++;
    if (evq.size() != 1 || !evq[0].is_err || evq[0].k !== 2'd1) begin
      n_fail++; $display("FAIL framing_stop: got %0d events kind %0d want 1 error kind 1",
                         evq.size(), (evq.size() > 0) ? evq[0].k : 2'bxx);
    end
    evq.delete();
    send_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(40);
    n_cmp++;
    if (evq.size() != 1 || !evq[0].is_err || evq[0].k !== 2'd1) begin
      n_fail++; $display("FAIL framing_start: got %0d events kind %0d want 1 error kind 1",
                         evq.size(), (evq.size() > 0) ? evq[0].k : 2'bxx);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL framing_start_idle: got busy %b want 0", busy_o);
    end
  endtask

  task automatic test_timeout();
    int exp_cyc;
    evq.delete();
    send_frame(8'h5E, 1'b0, 1'b1, 5, 1'b0);
    exp_cyc = last_fall_cyc + 3 + Filt + Tmo;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL timeout_busy: got %b want 1", busy_o);
    end
    for (int i = 0; i < Tmo + 300 && evq.size() == 0; i++) wait_cyc(1);
    n_cmp++;
    if (evq.size() != 1 || !evq[0].is_err || evq[0].k !== 2'd3) begin
      n_fail++; $display("FAIL timeout_err: got %0d events kind %0d want 1 error kind 3",
                         evq.size(), (evq.size() > 0) ? evq[0].k : 2'bxx);
    end
    n_cmp++;
    if (evq.size() < 1 || evq[0].cyc != exp_cyc) begin
      n_fail++; $display("FAIL timeout_cycle: got %0d want %0d",
                         (evq.size() > 0) ? evq[0].cyc : -1, exp_cyc);
    end
    wait_cyc(20);
    evq.delete();
    send_frame(8'h24, 1'b0, 1'b1, 11, 1'b0);
    n_cmp++;
    if (evq.size() != 1 || evq[0].is_err || data_o !== 8'h24) begin
      n_fail++; $display("FAIL timeout_recover: got %0d events data %h want 1 valid 24",
                         evq.size(), data_o);
    end
  endtask

  task automatic test_glitch();
    evq.delete();
    send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b1);
    n_cmp++;
    if (evq.size() != 1 || evq[0].is_err || evq[0].d !== 8'h4B) begin
      n_fail++; $display("FAIL glitch_4b: got %0d events d=%h want 1 valid 4b",
                         evq.size(), (evq.size() > 0) ? evq[0].d : 8'hxx);
    end
  endtask

  task automatic test_reset_midframe();
    evq.delete();
    send_frame(8'hC3, 1'b0, 1'b1, 7, 1'b0);
    reset_n = 1'b0;
    wait_cyc(3);
    n_cmp++;
    if ({data_o, valid_o, error_o, error_kind_o, busy_o} !== 13'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h want 0000",
                         {data_o, valid_o, error_o, error_kind_o, busy_o});
    end
    reset_n = 1'b1;
    wait_cyc(Tmo + 100);
    n_cmp++;
    if (evq.size() != 0 || busy_o !== 1'b0 || data_o !== 8'h00) begin
      n_fail++; $display("FAIL midreset_quiet: got %0d events busy %b data %h want 0 0 00",
                         evq.size(), busy_o, data_o);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    n_cmp++;
    if (evq.size() != 1 || evq[0].is_err || data_o !== 8'h5A) begin
      n_fail++; $display("FAIL midreset_next: got %0d events data %h want 1 valid 5a",
                         evq.size(), data_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, last_good;
    bit flip, stop_b;
    int exp;
    last_good = 8'h5A;
    for (int n = 0; n < 10; n++) begin
      d      = 8'($urandom);
      flip   = ($urandom_range(3) == 0);
      stop_b = ($urandom_range(5) != 0);
      exp    = frame_outcome(d, flip, stop_b);
      evq.delete();
      send_frame(d, flip, stop_b, 11, 1'($urandom_range(1)));
      if (exp == 0) last_good = d;
      n_cmp++;
      if (evq.size() != 1 || evq[0].is_err != (exp != 0) ||
          (exp != 0 && int'(evq[0].k) != exp) || (exp == 0 && evq[0].d !== d)) begin
        n_fail++; $display("FAIL random_%0d: byte %h got %0d events err=%0d k=%0d d=%h want outcome %0d",
                           n, d, evq.size(), (evq.size() > 0) ? evq[0].is_err : 1'b0,
                           (evq.size() > 0) ? evq[0].k : 2'bxx,
                           (evq.size() > 0) ? evq[0].d : 8'hxx, exp);
      end
      n_cmp++;
      if (data_o !== last_good) begin
        n_fail++; $display("FAIL random_hold_%0d: got %h want %h", n, data_o, last_good);
      end
      wait_cyc(int'($urandom_range(150, 20)));
    end
  endtask

  task automatic test_no_overlap();
    n_cmp++;
    if (overlap != 0) begin
      n_fail++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity_error();
    test_framing();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    test_no_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
